// File: rtl/ex_muldiv_unit.sv
// EX-stage multi-cycle multiply/divide unit owning the architectural HI/LO pair.
// Multiplies finish after MUL_CYCLES and divides after DIV_CYCLES; while an op is in flight, new ops and HI/LO reads stall.
module ex_muldiv_unit #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  Op,
    input  logic        Read,
    input  logic        Flush,
    input  logic [31:0] Rs_Data,
    input  logic [31:0] Rt_Data,
    output logic        Stall,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] OP_MULT  = 4'h1;
    localparam logic [3:0] OP_MULTU = 4'h2;
    localparam logic [3:0] OP_DIV   = 4'h3;
    localparam logic [3:0] OP_DIVU  = 4'h4;
    localparam logic [3:0] OP_MADD  = 4'h5;
    localparam logic [3:0] OP_MADDU = 4'h6;
    localparam logic [3:0] OP_MSUB  = 4'h7;
    localparam logic [3:0] OP_MSUBU = 4'h8;
    localparam logic [3:0] OP_MTHI  = 4'h9;
    localparam logic [3:0] OP_MTLO  = 4'hA;

    localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      opA_q, opA_d;
    logic [31:0]      opB_q, opB_d;
    logic [3:0]       op_q, op_d;
    logic [31:0]      rem_q, rem_d;
    logic [31:0]      quot_q, quot_d;
    logic [31:0]      divisor_q, divisor_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic        isMul, isDiv, isMtHi, isMtLo;
    logic        accept, lastCycle;
    logic        signedOp, qNeg, rNeg;
    logic [63:0] extA, extB, product, acc, mulResult, divResult;
    logic [32:0] remShift, diff;
    logic        quotBit;
    logic [31:0] remNext, quotNext;
    logic [31:0] magA, magB;

    always_comb begin
        isMul  = 1'b0;
        isDiv  = 1'b0;
        isMtHi = 1'b0;
        isMtLo = 1'b0;
        case (Op)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: isMul = 1'b1;
            OP_DIV, OP_DIVU:                                         isDiv = 1'b1;
            OP_MTHI:                                                 isMtHi = 1'b1;
            OP_MTLO:                                                 isMtLo = 1'b1;
            default: ;
        endcase
    end

    // Flush outranks Start, so a flushed cycle never accepts anything.
    assign accept    = (state_q == S_IDLE) && Start && !Flush;
    assign lastCycle = (state_q != S_IDLE) && !Flush && (cnt_q == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (Start && !Flush) begin
                    if (isMul) begin
                        state_d = S_MUL;
                    end else if (isDiv) begin
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (Flush || cnt_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        Busy  = (state_q != S_IDLE);
        Stall = Busy && (Start || Read);
    end

    assign signedOp = (op_q == OP_MULT) || (op_q == OP_MADD) ||
                      (op_q == OP_MSUB) || (op_q == OP_DIV);

    // The low 64 bits of the product of the sign-extended operands equal the signed product,
    // so a single multiplier serves both the signed and the unsigned forms.
    always_comb begin
        extA    = {{32{signedOp & opA_q[31]}}, opA_q};
        extB    = {{32{signedOp & opB_q[31]}}, opB_q};
        product = extA * extB;
        acc     = {hi_q, lo_q};
        case (op_q)
            OP_MADD, OP_MADDU: mulResult = acc + product;
            OP_MSUB, OP_MSUBU: mulResult = acc - product;
            default:           mulResult = product;
        endcase
    end

    always_comb begin
        remShift = {rem_q, quot_q[31]};
        diff     = remShift - {1'b0, divisor_q};
        quotBit  = !diff[32];
        remNext  = quotBit ? diff[31:0] : remShift[31:0];
        quotNext = {quot_q[30:0], quotBit};
        qNeg     = (op_q == OP_DIV) && (opA_q[31] ^ opB_q[31]);
        rNeg     = (op_q == OP_DIV) && opA_q[31];
        if (opB_q == 32'd0) begin
            divResult = {opA_q, 32'hFFFF_FFFF};
        end else begin
            divResult = {(rNeg ? -remNext : remNext), (qNeg ? -quotNext : quotNext)};
        end
    end

    assign magA = (Op == OP_DIV && Rs_Data[31]) ? -Rs_Data : Rs_Data;
    assign magB = (Op == OP_DIV && Rt_Data[31]) ? -Rt_Data : Rt_Data;

    always_comb begin
        cnt_d     = cnt_q;
        opA_d     = opA_q;
        opB_d     = opB_q;
        op_d      = op_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        divisor_d = divisor_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        if (accept) begin
            opA_d = Rs_Data;
            opB_d = Rt_Data;
            op_d  = Op;
            if (isMul) begin
                cnt_d = MUL_LOAD;
            end else if (isDiv) begin
                cnt_d     = DIV_LOAD;
                rem_d     = 32'd0;
                quot_d    = magA;
                divisor_d = magB;
            end else if (isMtHi) begin
                hi_d = Rs_Data;
            end else if (isMtLo) begin
                lo_d = Rs_Data;
            end
        end else if (state_q != S_IDLE && !Flush) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
            if (state_q == S_DIV) begin
                rem_d  = remNext;
                quot_d = quotNext;
            end
        end

        if (lastCycle) begin
            if (state_q == S_MUL) begin
                {hi_d, lo_d} = mulResult;
            end else begin
                {hi_d, lo_d} = divResult;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            opA_q     <= 32'd0;
            opB_q     <= 32'd0;
            op_q      <= 4'd0;
            rem_q     <= 32'd0;
            quot_q    <= 32'd0;
            divisor_q <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            cnt_q     <= cnt_d;
            opA_q     <= opA_d;
            opB_q     <= opB_d;
            op_q      <= op_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            divisor_q <= divisor_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign HI = hi_q;
    assign LO = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: a reference model pushes expected {HI,LO} into a scoreboard
// queue at issue, and entries are popped and compared when the unit drops Busy.
module tb_ex_muldiv_unit;

    localparam int MUL_CYCLES = 2;

    logic        clock;
    logic        reset;
    logic        Start;
    logic [3:0]  Op;
    logic        Read;
    logic        Flush;
    logic [31:0] Rs_Data;
    logic [31:0] Rt_Data;
    logic        Stall;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int          vectors;
    int          miscompares;
    logic [63:0] sbQ[$];
    logic [31:0] modelHi;
    logic [31:0] modelLo;

    ex_muldiv_unit #(.MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(32)) dut (
        .clock   (clock),
        .reset   (reset),
        .Start   (Start),
        .Op      (Op),
        .Read    (Read),
        .Flush   (Flush),
        .Rs_Data (Rs_Data),
        .Rt_Data (Rt_Data),
        .Stall   (Stall),
        .Busy    (Busy),
        .HI      (HI),
        .LO      (LO)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference behaviour written from the architectural definition using native SV arithmetic.
    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                          input logic [31:0] hi, input logic [31:0] lo);
        logic [63:0] acc, pu, ps;
        int          sa, sb;
        acc = {hi, lo};
        sa  = rs;
        sb  = rt;
        pu  = {32'd0, rs} * {32'd0, rt};
        ps  = longint'(sa) * longint'(sb);
        case (op)
            4'h1: model = ps;
            4'h2: model = pu;
            4'h5: model = acc + ps;
            4'h6: model = acc + pu;
            4'h7: model = acc - ps;
            4'h8: model = acc - pu;
            4'h3: begin
                if (rt == 32'd0)                                  model = {rs, 32'hFFFF_FFFF};
                else if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) model = {32'd0, 32'h8000_0000};
                else                                              model = {32'(sa % sb), 32'(sa / sb)};
            end
            4'h4: begin
                if (rt == 32'd0) model = {rs, 32'hFFFF_FFFF};
                else             model = {rs % rt, rs / rt};
            end
            4'h9:    model = {rs, lo};
            4'hA:    model = {hi, rs};
            default: model = acc;
        endcase
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pushExpected(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
        logic [63:0] exp;
        exp = model(op, rs, rt, modelHi, modelLo);
        sbQ.push_back(exp);
        {modelHi, modelLo} = exp;
    endtask

    task automatic checkResult(input string tag);
        if (sbQ.size() == 0) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected scoreboard entry (queue empty)", tag, {HI, LO});
        end else begin
            checkOutput(tag, {HI, LO}, sbQ.pop_front());
        end
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
        Start   = 1'b1;
        Op      = op;
        Rs_Data = rs;
        Rt_Data = rt;
        tick();
        Start   = 1'b0;
        Op      = 4'h0;
        Rs_Data = $urandom;
        Rt_Data = $urandom;
    endtask

    task automatic runOp(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt, input string tag);
        int expCycles;
        int cnt;
        if (op inside {4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'h8})
            expCycles = MUL_CYCLES;
        else if (op inside {4'h3, 4'h4})
            expCycles = 32;
        else
            expCycles = 0;
        pushExpected(op, rs, rt);
        applyStimulus(op, rs, rt);
        cnt = 0;
        while (Busy === 1'b1 && cnt < 200) begin
            cnt++;
            tick();
        end
        checkOutput({tag, "_cycles"}, 64'(cnt), 64'(expCycles));
        checkResult(tag);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        modelHi     = 32'd0;
        modelLo     = 32'd0;
        reset       = 1'b0;
        Start       = 1'b0;
        Op          = 4'h0;
        Read        = 1'b0;
        Flush       = 1'b0;
        Rs_Data     = 32'd0;
        Rt_Data     = 32'd0;

        repeat (2) tick();
        checkOutput("reset_busy", 64'(Busy), 64'd0);
        checkOutput("reset_stall", 64'(Stall), 64'd0);
        checkOutput("reset_hilo", {HI, LO}, 64'd0);
        reset = 1'b1;
        tick();

        runOp(4'h1, 32'hFFFF_FFFF, 32'h0000_0002, "mult");
        checkOutput("mult_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFE);
        runOp(4'h2, 32'hFFFF_FFFF, 32'h0000_0002, "multu");
        checkOutput("multu_const", {HI, LO}, 64'h0000_0001_FFFF_FFFE);
        runOp(4'h3, 32'hFFFF_FFF9, 32'h0000_0002, "div_neg7_2");
        checkOutput("div_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        runOp(4'h4, 32'd100, 32'd0, "divu_by0");
        checkOutput("divu_by0_const", {HI, LO}, 64'h0000_0064_FFFF_FFFF);
        runOp(4'h3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        checkOutput("div_ovf_const", {HI, LO}, 64'h0000_0000_8000_0000);

        runOp(4'h9, 32'd5, 32'd0, "mthi");
        runOp(4'hA, 32'd7, 32'd0, "mtlo");
        runOp(4'h5, 32'd3, 32'd4, "madd");
        checkOutput("madd_const", {HI, LO}, 64'h0000_0005_0000_0013);
        runOp(4'h9, 32'd0, 32'd0, "mthi0");
        runOp(4'hA, 32'd0, 32'd0, "mtlo0");
        runOp(4'h7, 32'd1, 32'd1, "msub");
        checkOutput("msub_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFF);

        // Reads and a new start during a divide stall; the queued start goes in after completion.
        pushExpected(4'h3, 32'd1000, 32'd7);
        applyStimulus(4'h3, 32'd1000, 32'd7);
        Read = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            #1;
            checkOutput($sformatf("stall_read_c%0d", i), 64'(Stall), 64'd1);
            tick();
        end
        Start   = 1'b1;
        Op      = 4'h2;
        Rs_Data = 32'd6;
        Rt_Data = 32'd7;
        #1;
        checkOutput("stall_last_busy", 64'(Stall), 64'd1);
        checkOutput("busy_last_cycle", 64'(Busy), 64'd1);
        tick();
        checkOutput("stall_after_done", 64'(Stall), 64'd0);
        checkOutput("busy_after_done", 64'(Busy), 64'd0);
        checkResult("div_stall_result");
        pushExpected(4'h2, 32'd6, 32'd7);
        tick();
        Start = 1'b0;
        Read  = 1'b0;
        Op    = 4'h0;
        checkOutput("held_start_accepted", 64'(Busy), 64'd1);
        begin
            int cnt;
            cnt = 0;
            while (Busy === 1'b1 && cnt < 200) begin
                cnt++;
                tick();
            end
            checkOutput("held_start_cycles", 64'(cnt), 64'(MUL_CYCLES));
        end
        checkResult("held_multu");

        // Flush in busy cycle 10 aborts the divide and leaves HI/LO alone.
        runOp(4'h9, 32'hA5A5_A5A5, 32'd0, "pre_hi");
        runOp(4'hA, 32'hA5A5_A5A5, 32'd0, "pre_lo");
        applyStimulus(4'h3, 32'd77, 32'd5);
        repeat (9) tick();
        checkOutput("flush_busy_before", 64'(Busy), 64'd1);
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        checkOutput("flush_busy_after", 64'(Busy), 64'd0);
        repeat (30) tick();
        checkOutput("flush_hilo", {HI, LO}, 64'hA5A5_A5A5_A5A5_A5A5);

        Flush   = 1'b1;
        Start   = 1'b1;
        Op      = 4'h1;
        Rs_Data = 32'd3;
        Rt_Data = 32'd3;
        tick();
        Flush = 1'b0;
        Start = 1'b0;
        Op    = 4'h0;
        checkOutput("flush_start_busy", 64'(Busy), 64'd0);
        repeat (3) tick();
        checkOutput("flush_start_hilo", {HI, LO}, 64'hA5A5_A5A5_A5A5_A5A5);

        applyStimulus(4'hB, 32'd9, 32'd9);
        checkOutput("reserved_busy", 64'(Busy), 64'd0);
        tick();
        checkOutput("reserved_hilo", {HI, LO}, 64'hA5A5_A5A5_A5A5_A5A5);

        for (int i = 0; i < 6; i++) begin
            logic [3:0]  rop;
            logic [31:0] rrs, rrt;
            rop = 4'($urandom_range(1, 8));
            rrs = $urandom;
            rrt = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 50)) : $urandom;
            if (i == 5) rrt = 32'd0;
            runOp(rop, rrs, rrt, $sformatf("rand%0d_op%0h", i, rop));
        end

        // Asynchronous reset lands mid-divide.
        applyStimulus(4'h4, 32'd500, 32'd3);
        repeat (5) tick();
        reset = 1'b0;
        #1;
        checkOutput("rst_mid_hilo", {HI, LO}, 64'd0);
        checkOutput("rst_mid_busy", 64'(Busy), 64'd0);
        modelHi = 32'd0;
        modelLo = 32'd0;
        tick();
        reset = 1'b1;
        tick();
        runOp(4'h2, 32'd3, 32'd3, "post_rst_multu");
        checkOutput("post_rst_const", {HI, LO}, 64'd9);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
